// File: rtl/mem_ctrl_pkg.sv
// Shared types and lane helpers for the load/store memory access controller.
// Data path is fixed at 64 bits (8 byte lanes).
package mem_ctrl_pkg;

    localparam int DATA_W = 64;
    localparam int LANES  = 8;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    // Byte enables of an access of the given size, before shifting into its lanes.
    function automatic logic [LANES-1:0] lane_mask(input size_t sz);
        case (sz)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Address bits that must be zero for an access of the given size to be aligned.
    function automatic logic [2:0] size_low_bits(input size_t sz);
        case (sz)
            SZ_B:    return 3'b000;
            SZ_H:    return 3'b001;
            SZ_W:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load return path: shifts the raw 64-bit line down by the byte offset, then
// sign- or zero-extends a byte/half/word; dwords pass through unchanged.
module load_extend
    import mem_ctrl_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  off,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [63:0] data
);

    logic [63:0] s;

    assign s = rdata >> {off, 3'b000};

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        data = s;
        case (size_t'(size))
            SZ_B:    data = {{56{sgn & s[7]}},  s[7:0]};
            SZ_H:    data = {{48{sgn & s[15]}}, s[15:0]};
            SZ_W:    data = {{32{sgn & s[31]}}, s[31:0]};
            default: data = s;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store sequencer for the shared 64-bit data memory.
// Optional macro MISALIGN_TRAP_EN: misaligned requests return an error without a memory access.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int          XLEN        = 64,
    parameter int          ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t              state, state_d;
    logic                we_q, sgn_q;
    size_t               size_q;
    logic [ADDR_W-4:0]   line_q;
    logic [XLEN-1:0]     wdata_q;
    logic [2:0]          off_q;
    logic [CNT_W-1:0]    cnt;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [XLEN-1:0]     ext_data;
    logic [2:0]          req_low;
    logic                timeout_hit;

    assign req_low     = size_low_bits(size_t'(req_size));
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TIMEOUT_CYC - 1));

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = |(req_addr[2:0] & req_low);
`endif

    load_extend u_load_extend (
        .rdata (mem_rdata),
        .off   (off_q),
        .size  (size_q),
        .sgn   (sgn_q),
        .data  (ext_data)
    );

    // NOTE: state and datapath registers use non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt     <= (state == ACCESS) ? cnt + 1'b1 : '0;
        end
    end

    // Request latch; the stored offset is already aligned, which is how the
    // non-trapping build forces misaligned accesses onto their natural boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= SZ_B;
            line_q  <= '0;
            wdata_q <= '0;
            off_q   <= '0;
        end else if (state == IDLE && req_valid) begin
            we_q    <= req_we;
            sgn_q   <= req_signed;
            size_q  <= size_t'(req_size);
            line_q  <= req_addr[ADDR_W-1:3];
            wdata_q <= req_wdata;
            off_q   <= req_addr[2:0] & ~req_low;
        end
    end

    always_comb begin
        state_d = state;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state)
            IDLE: begin
                if (req_valid) begin
`ifdef MISALIGN_TRAP_EN
                    if (misaligned) begin
                        state_d = RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ACCESS;
                    end
`else
                    state_d = ACCESS;
`endif
                end
            end
            ACCESS: begin
                // An ack in the final timeout cycle still completes normally.
                if (mem_ack) begin
                    state_d = RESP;
                    rdata_d = we_q ? '0 : ext_data;
                    err_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE) | req_valid;
    assign mem_req   = (state == ACCESS);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? {line_q, 3'b000} : '0;
    assign mem_be    = mem_req ? (lane_mask(size_q) << off_q) : '0;
    assign mem_wdata = mem_req ? (wdata_q << {off_q, 3'b000}) : '0;
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: table of single transactions plus
// hand-written timeout, stray-ack and mid-transaction reset sequences.
module tb_mem_access_ctrl;

    localparam int TO = 4;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid, rsp_err, busy;
    logic [63:0] rsp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata, mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_access_ctrl #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          d;
        logic        touch;
        logic [7:0]  be;
        logic [63:0] ewdata;
        logic [63:0] erdata;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic we, input logic [1:0] size,
                                input logic sgn, input logic [31:0] addr, input logic [63:0] wdata,
                                input logic [63:0] rdata, input int d, input logic touch,
                                input logic [7:0] be, input logic [63:0] ewdata,
                                input logic [63:0] erdata, input logic err);
        vec_t v;
        v.name = name; v.we = we; v.size = size; v.sgn = sgn; v.addr = addr;
        v.wdata = wdata; v.rdata = rdata; v.d = d; v.touch = touch; v.be = be;
        v.ewdata = ewdata; v.erdata = erdata; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        check({v.name, " req_ready"}, 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        #1;
        check({v.name, " busy idle"}, 64'(busy), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        #1;
        if (v.touch) begin
            check({v.name, " mem_req"},   64'(mem_req),   64'd1);
            check({v.name, " mem_we"},    64'(mem_we),    64'(v.we));
            check({v.name, " mem_addr"},  64'(mem_addr),  64'(v.addr & 32'hFFFF_FFF8));
            check({v.name, " mem_be"},    64'(mem_be),    64'(v.be));
            check({v.name, " mem_wdata"}, mem_wdata,      v.ewdata);
            check({v.name, " req_ready"}, 64'(req_ready), 64'd0);
            check({v.name, " busy acc"},  64'(busy),      64'd1);
            mem_rdata = 64'hA5A5_5A5A_A5A5_5A5A;
            for (int i = 0; i < v.d; i++) begin
                @(negedge clk);
                check({v.name, " mem_req wait"}, 64'(mem_req), 64'd1);
            end
            mem_ack   = 1'b1;
            mem_rdata = v.rdata;
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = '0;
            #1;
            check({v.name, " mem_req after ack"}, 64'(mem_req), 64'd0);
        end else begin
            check({v.name, " no mem_req"}, 64'(mem_req), 64'd0);
        end
        check({v.name, " rsp_valid"}, 64'(rsp_valid), 64'd1);
        check({v.name, " rsp_rdata"}, rsp_rdata,      v.erdata);
        check({v.name, " rsp_err"},   64'(rsp_err),   64'(v.err));
        @(negedge clk);
        check({v.name, " rsp pulse"}, 64'(rsp_valid), 64'd0);
        check({v.name, " ready back"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int rsp_at;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

        //          name       we  sz     sgn  addr           wdata                   rdata                   d  touch be     ewdata                  erdata                  err
        vecs.push_back(mk("lb",   0, 2'b00, 1, 32'h0000_0103, 64'h0,                  64'h0000_0000_8000_0000, 0, 1, 8'h08, 64'h0,                  64'hFFFF_FFFF_FFFF_FF80, 0));
        vecs.push_back(mk("lhu",  0, 2'b01, 0, 32'h0000_0106, 64'h0,                  64'hBEEF_0000_0000_0000, 1, 1, 8'hC0, 64'h0,                  64'h0000_0000_0000_BEEF, 0));
        vecs.push_back(mk("sw",   1, 2'b10, 0, 32'h0000_0104, 64'h1234_5678,          64'hDEAD_BEEF_DEAD_BEEF, 2, 1, 8'hF0, 64'h1234_5678_0000_0000, 64'h0,                  0));
        vecs.push_back(mk("ld",   0, 2'b11, 0, 32'h0000_0108, 64'h0,                  64'h0123_4567_89AB_CDEF, 3, 1, 8'hFF, 64'h0,                  64'h0123_4567_89AB_CDEF, 0));
        vecs.push_back(mk("lh",   0, 2'b01, 1, 32'h0000_010A, 64'h0,                  64'h0000_0000_8001_0000, 0, 1, 8'h0C, 64'h0,                  64'hFFFF_FFFF_FFFF_8001, 0));
        vecs.push_back(mk("sb",   1, 2'b00, 0, 32'h0000_00FF, 64'hAB,                 64'h0,                  1, 1, 8'h80, 64'hAB00_0000_0000_0000, 64'h0,                  0));
        vecs.push_back(mk("lwu",  0, 2'b10, 0, 32'h0000_0204, 64'h0,                  64'hF000_0001_0000_0000, 0, 1, 8'hF0, 64'h0,                  64'h0000_0000_F000_0001, 0));
        vecs.push_back(mk("sd",   1, 2'b11, 0, 32'h0000_0300, 64'hCAFE_F00D_1234_5678, 64'h0,                  2, 1, 8'hFF, 64'hCAFE_F00D_1234_5678, 64'h0,                  0));
        vecs.push_back(mk("lbu",  0, 2'b00, 0, 32'h0000_0007, 64'h0,                  64'hFF00_0000_0000_0000, 0, 1, 8'h80, 64'h0,                  64'h0000_0000_0000_00FF, 0));
`ifdef MISALIGN_TRAP_EN
        vecs.push_back(mk("lw mis",  0, 2'b10, 1, 32'h0000_0102, 64'h0,                  64'h0,                  0, 0, 8'h00, 64'h0,                  64'h0,                  1));
        vecs.push_back(mk("lh mis",  0, 2'b01, 1, 32'h0000_0101, 64'h0,                  64'h0,                  0, 0, 8'h00, 64'h0,                  64'h0,                  1));
        vecs.push_back(mk("sd mis",  1, 2'b11, 0, 32'h0000_0301, 64'hCAFE_F00D_1234_5678, 64'h0,                  0, 0, 8'h00, 64'h0,                  64'h0,                  1));
`else
        vecs.push_back(mk("lw mis",  0, 2'b10, 1, 32'h0000_0102, 64'h0,                  64'h1111_1111_8765_4321, 0, 1, 8'h0F, 64'h0,                  64'hFFFF_FFFF_8765_4321, 0));
        vecs.push_back(mk("lh mis",  0, 2'b01, 1, 32'h0000_0101, 64'h0,                  64'h0000_0000_0000_FF7F, 1, 1, 8'h03, 64'h0,                  64'hFFFF_FFFF_FFFF_FF7F, 0));
        vecs.push_back(mk("sd mis",  1, 2'b11, 0, 32'h0000_0301, 64'hCAFE_F00D_1234_5678, 64'h0,                  0, 1, 8'hFF, 64'hCAFE_F00D_1234_5678, 64'h0,                  0));
`endif

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("reset req_ready", 64'(req_ready), 64'd1);
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset rsp_rdata", rsp_rdata,      64'd0);
        check("reset rsp_err",   64'(rsp_err),   64'd0);
        check("reset busy",      64'(busy),      64'd0);
        check("reset mem_req",   64'(mem_req),   64'd0);
        check("reset mem_be",    64'(mem_be),    64'd0);
        check("reset mem_wdata", mem_wdata,      64'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Timeout: ack never comes, so mem_req lasts exactly TO cycles.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b11; req_signed = 1'b0; req_addr = 32'h200;
        @(negedge clk);
        req_valid = 1'b0;
        hi = 0;
        rsp_at = -1;
        for (int c = 1; c <= 20 && rsp_at < 0; c++) begin
            if (c > 1) @(negedge clk);
            if (mem_req) hi++;
            if (rsp_valid) begin
                rsp_at = c;
                check("timeout rsp_err",   64'(rsp_err), 64'd1);
                check("timeout rsp_rdata", rsp_rdata,    64'd0);
            end
        end
        check("timeout mem_req cycles", 64'(hi),     64'(TO));
        check("timeout rsp cycle",      64'(rsp_at), 64'(TO + 1));
        @(negedge clk);
        check("timeout rsp pulse", 64'(rsp_valid), 64'd0);
        check("timeout ready",     64'(req_ready), 64'd1);

        // Stray ack while idle is ignored.
        mem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("stray ack rsp_valid", 64'(rsp_valid), 64'd0);
        check("stray ack mem_req",   64'(mem_req),   64'd0);
        check("stray ack ready",     64'(req_ready), 64'd1);
        mem_ack = 1'b0;

        // Reset during ACCESS aborts with no response.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_addr = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort mem_req before", 64'(mem_req), 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort mem_req async", 64'(mem_req),   64'd0);
        check("abort ready",         64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort no rsp", 64'(rsp_valid), 64'd0);
        end
        check("abort ready after", 64'(req_ready), 64'd1);

        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
